// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle between multicycle_ctrl (master) and the datapath/memory side (slave).
// Carries the instruction/flag inputs, the memory handshake and all datapath controls.
interface multicycle_ctrl_if #(parameter int n = 16);
  logic [n-1:0] instr;
  logic         zero;
  logic         mem_ready;
  logic         mem_req;
  logic         memwrite;
  logic         irwrite;
  logic         pcen;
  logic         memtoreg;
  logic         pcsrc;
  logic         alusrc;
  logic         regdst;
  logic         regwrite;
  logic         jump;
  logic [3:0]   alucontrol;
  logic         halted;
  logic         illegal;
  logic [15:0]  instret;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, memwrite, irwrite, pcen, memtoreg, pcsrc, alusrc,
           regdst, regwrite, jump, alucontrol, halted, illegal, instret
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, memwrite, irwrite, pcen, memtoreg, pcsrc, alusrc,
           regdst, regwrite, jump, alucontrol, halted, illegal, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit CPU: fetch/decode/exec/mem/wb sequencing,
// opcode decode, memory request/ready handshake, retire counter and sticky illegal flag.
module multicycle_ctrl #(
  parameter int n = 16
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;

  logic [3:0] opcode;
  logic [2:0] funct;
  logic       unused_instr_bits;

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_jr, is_halt, is_bad;

  logic       mem_req, memwrite, irwrite, pcen, memtoreg, pcsrc;
  logic       alusrc, regdst, regwrite, jump, retire;
  logic [3:0] alucontrol;

  assign opcode            = bus.instr[n-1 -: 4];
  assign funct             = bus.instr[n-5 -: 3];
  assign unused_instr_bits = ^bus.instr[n-8:0];

  always_comb begin
    is_r    = (opcode == 4'b0000);
    is_addi = (opcode == 4'b0001);
    is_lw   = (opcode == 4'b0010);
    is_sw   = (opcode == 4'b0011);
    is_beq  = (opcode == 4'b0100);
    is_jr   = (opcode == 4'b0101);
    is_halt = (opcode == 4'b1111);
    is_bad  = !(is_r || is_addi || is_lw || is_sw || is_beq || is_jr || is_halt);
  end

  // Controls are pure decode of state and instr; reset forces every control low.
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    jump       = 1'b0;
    alucontrol = 4'b0000;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          irwrite = bus.mem_ready;
        end
        S_EXEC: begin
          if (is_r) begin
            alucontrol = {1'b0, funct};
          end else if (is_addi || is_lw || is_sw) begin
            alusrc     = 1'b1;
            alucontrol = 4'b0010;
          end else if (is_beq) begin
            alucontrol = 4'b0110;
            pcen       = 1'b1;
            pcsrc      = bus.zero;
          end else if (is_jr) begin
            pcen = 1'b1;
            jump = 1'b1;
          end else if (is_bad) begin
            pcen = 1'b1;
          end
        end
        S_MEM: begin
          mem_req    = 1'b1;
          memwrite   = is_sw;
          alusrc     = 1'b1;
          alucontrol = 4'b0010;
          pcen       = bus.mem_ready && is_sw;
        end
        S_WB: begin
          regwrite = 1'b1;
          pcen     = 1'b1;
          regdst   = is_r;
          memtoreg = is_lw;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_r || is_addi)      state_d = S_WB;
        else if (is_lw || is_sw)  state_d = S_MEM;
        else if (is_halt)         state_d = S_HALT;
        else                      state_d = S_FETCH;
      end
      S_MEM:    if (bus.mem_ready) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // HALT has no pcen, so its retirement is counted on the EXEC-to-HALT edge instead.
  always_comb begin
    retire    = pcen || (state_q == S_EXEC && is_halt);
    instret_d = instret_q + {15'd0, retire};
    illegal_d = illegal_q || (state_q == S_DECODE && is_bad);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= 16'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.pcen       = pcen;
  assign bus.memtoreg   = memtoreg;
  assign bus.pcsrc      = pcsrc;
  assign bus.alusrc     = alusrc;
  assign bus.regdst     = regdst;
  assign bus.regwrite   = regwrite;
  assign bus.jump       = jump;
  assign bus.alucontrol = alucontrol;
  assign bus.halted     = !reset && (state_q == S_HALT);
  assign bus.illegal    = illegal_q;
  assign bus.instret    = instret_q;

endmodule
